// File: rtl/mips_dcache_if.sv
// Core-side request/response and backing-memory signals of the direct-mapped data cache.
// Words are packed as four bytes with byte [0] in bits 31:24.
interface mips_dcache_if;
  logic             cache_en;
  logic             cache_we;
  logic [31:0]      cache_addr;
  logic [0:3][7:0]  cache_data_in;
  logic [0:3][7:0]  cache_data_out;
  logic             hit;
  logic [31:0]      mem_addr;
  logic [0:3][7:0]  mem_data_in;
  logic [0:3][7:0]  mem_data_out;
  logic             mem_write_en;

  modport master (
    output cache_en, cache_we, cache_addr, cache_data_in, mem_data_out,
    input  cache_data_out, hit, mem_addr, mem_data_in, mem_write_en
  );

  modport slave (
    input  cache_en, cache_we, cache_addr, cache_data_in, mem_data_out,
    output cache_data_out, hit, mem_addr, mem_data_in, mem_write_en
  );
endinterface

// File: rtl/mips_dcache.sv
// Direct-mapped one-word-line write-through data cache; DCACHE_WRITE_ALLOCATE_EN installs store misses.
// Load hit same cycle, miss/store MEM_LATENCY+1 cycles; core holds cache_en until hit, later input changes ignored.
module mips_dcache #(
  parameter int LINES       = 64,
  parameter int MEM_LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  mips_dcache_if.slave bus
);
  localparam int         IB  = $clog2(LINES);
  localparam int         TW  = 30 - IB;
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      maddr_q, maddr_d;
  logic [31:0]      mdata_q, mdata_d;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_arr  [LINES];
  logic [31:0]      data_arr [LINES];

  logic [IB-1:0]    req_idx, lat_idx;
  logic [TW-1:0]    req_tag, lat_tag;
  logic             req_hit, lat_match, last_wait, fill, st_last;
  logic             hit_c, mwe_c;
  logic             unused_addr_bits;

  assign req_idx   = bus.cache_addr[2+IB-1:2];
  assign req_tag   = bus.cache_addr[31:2+IB];
  assign lat_idx   = maddr_q[2+IB-1:2];
  assign lat_tag   = maddr_q[31:2+IB];
  assign req_hit   = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
  assign lat_match = valid_q[lat_idx] && (tag_arr[lat_idx] == lat_tag);
  assign last_wait = (cnt_q <= 4'd1);
  assign fill      = (state_q == RD_WAIT) && last_wait;
  assign st_last   = (state_q == WR_WAIT) && last_wait;
  assign unused_addr_bits = ^{bus.cache_addr[1:0], maddr_q[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    hit_c   = 1'b0;
    mwe_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cache_en) begin
          if (bus.cache_we) begin
            maddr_d = {bus.cache_addr[31:2], 2'b00};
            mdata_d = bus.cache_data_in;
            cnt_d   = LAT;
            state_d = WR_WAIT;
          end else if (req_hit) begin
            hit_c = 1'b1;
          end else begin
            maddr_d = {bus.cache_addr[31:2], 2'b00};
            cnt_d   = LAT;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        mwe_c = (state_q == WR_WAIT);
        // Clamp at zero so a latency of 1 still gives exactly one wait cycle.
        if (last_wait) begin
          cnt_d   = '0;
          state_d = (state_q == WR_WAIT) ? DONE : IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        hit_c   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      if (fill) begin
        valid_q[lat_idx] <= 1'b1;
      end
`ifdef DCACHE_WRITE_ALLOCATE_EN
      else if (st_last) begin
        valid_q[lat_idx] <= 1'b1;
      end
`endif
    end
  end

  // Tag/data arrays are unreset; valid bits mask stale contents.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_arr[lat_idx]  <= lat_tag;
      data_arr[lat_idx] <= bus.mem_data_out;
    end else if (st_last) begin
`ifdef DCACHE_WRITE_ALLOCATE_EN
      tag_arr[lat_idx]  <= lat_tag;
      data_arr[lat_idx] <= mdata_q;
`else
      if (lat_match) begin
        data_arr[lat_idx] <= mdata_q;
      end
`endif
    end
  end

  assign bus.hit            = hit_c;
  assign bus.mem_write_en   = mwe_c;
  assign bus.mem_addr       = maddr_q;
  assign bus.mem_data_in    = mdata_q;
  assign bus.cache_data_out = (rst_b && valid_q[req_idx]) ? data_arr[req_idx] : 32'h0;
endmodule

// File: tb/tb_mips_dcache.sv
// Directed and random load/store traffic against a word-level reference cache and memory model.
module tb_mips_dcache;
  localparam int LINES = 64;
  localparam int IB    = 6;
  localparam int L     = 4;

  logic clk = 1'b0;
  logic rst_b;
  int   checks = 0;
  int   failures = 0;

  mips_dcache_if bus();

  mips_dcache #(.LINES(LINES), .MEM_LATENCY(L)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: backing memory by word address, cache lines by index.
  logic [31:0] mem [logic [31:0]];
  bit          rv [LINES];
  logic [31:0] rt [LINES];
  logic [31:0] rd [LINES];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return {w[15:0], ~w[15:0]} ^ 32'h3C5A_0000;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (2 + IB);
  endfunction

  function automatic bit ref_hit(input logic [31:0] a);
    return rv[idx_of(a)] && (rt[idx_of(a)] == tag_of(a));
  endfunction

  function automatic void ref_install(input logic [31:0] a, input logic [31:0] d);
    rv[idx_of(a)] = 1'b1;
    rt[idx_of(a)] = tag_of(a);
    rd[idx_of(a)] = d;
  endfunction

  function automatic void ref_load(input logic [31:0] a, input int chg, input logic [31:0] a2,
                                   output int lat, output logic [31:0] d);
    if (ref_hit(a)) begin
      lat = 0;
      d   = rd[idx_of(a)];
      return;
    end
    ref_install(a, mem_word(a));
    lat = L + 1;
    d   = mem_word(a);
    if (chg >= 0) begin
      if (ref_hit(a2)) begin
        d = rd[idx_of(a2)];
      end else begin
        ref_install(a2, mem_word(a2));
        lat = 2 * (L + 1);
        d   = mem_word(a2);
      end
    end
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [31:0] d);
    mem[{a[31:2], 2'b00}] = d;
    if (ref_hit(a)) rd[idx_of(a)] = d;
`ifdef DCACHE_WRITE_ALLOCATE_EN
    else ref_install(a, d);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request held until hit; samples each cycle 2 time units after the falling edge.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input int chg, input logic [31:0] a2,
                        output int lat, output logic [31:0] dout, output int wcnt, output bit ok);
    lat  = -1;
    dout = '0;
    wcnt = 0;
    ok   = 1'b1;
    @(negedge clk);
    bus.cache_we      = we;
    bus.cache_addr    = a;
    bus.cache_data_in = d;
    bus.cache_en      = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      bus.mem_data_out = mem_word(bus.mem_addr);
      #1;
      if (bus.mem_write_en) begin
        wcnt++;
        if (bus.mem_addr !== {a[31:2], 2'b00} || bus.mem_data_in !== d) ok = 1'b0;
      end
      if (bus.hit) begin
        lat  = k;
        dout = bus.cache_data_out;
        break;
      end
      if (k == chg) bus.cache_addr = a2;
      @(negedge clk);
    end
    @(negedge clk);
    bus.cache_en = 1'b0;
    #2;
    check("post_hit_low", {31'b0, bus.hit}, 32'h0);
  endtask

  task automatic run_load(input string tag, input logic [31:0] a, input int chg, input logic [31:0] a2,
                          output int lat, output logic [31:0] dout);
    int          elat, wcnt;
    logic [31:0] edata;
    bit          ok;
    ref_load(a, chg, a2, elat, edata);
    do_req(1'b0, a, 32'h0, chg, a2, lat, dout, wcnt, ok);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_data"}, dout, edata);
    check({tag, "_wen"}, 32'(wcnt), 32'h0);
  endtask

  task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] d);
    int          lat, wcnt;
    logic [31:0] dout;
    bit          ok;
    do_req(1'b1, a, d, -1, 32'h0, lat, dout, wcnt, ok);
    ref_store(a, d);
    check({tag, "_lat"}, 32'(lat), 32'(L + 1));
    check({tag, "_wen"}, 32'(wcnt), 32'(L));
    check({tag, "_memif"}, {31'b0, ok}, 32'h1);
  endtask

  function automatic logic [31:0] rnd_addr();
    return (32'($urandom_range(0, 3)) << (2 + IB)) | (32'($urandom_range(0, 3)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  int              lat;
  logic [31:0]     dout;
  logic [0:3][7:0] bytes;
  logic [31:0]     ra, ra2;

  initial begin
    rst_b             = 1'b0;
    bus.cache_en      = 1'b0;
    bus.cache_we      = 1'b0;
    bus.cache_addr    = 32'h0;
    bus.cache_data_in = 32'h0;
    bus.mem_data_out  = 32'h0;
    mem[32'h10]       = 32'hDEAD_BEEF;
    #2;
    check("rst_hit", {31'b0, bus.hit}, 32'h0);
    check("rst_wen", {31'b0, bus.mem_write_en}, 32'h0);
    check("rst_maddr", bus.mem_addr, 32'h0);
    check("rst_mdata", bus.mem_data_in, 32'h0);
    check("rst_dout", bus.cache_data_out, 32'h0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;

    // Cold fill and same-cycle repeat.
    run_load("fill10", 32'h10, -1, 32'h0, lat, dout);
    bytes = dout;
    check("fill10_lat_const", 32'(lat), 32'd5);
    check("fill10_b0", {24'b0, bytes[0]}, 32'hDE);
    check("fill10_b3", {24'b0, bytes[3]}, 32'hEF);
    run_load("rep10", 32'h10, -1, 32'h0, lat, dout);
    check("rep10_lat_const", 32'(lat), 32'd0);

    // Idle with cache_en low still shows the indexed word.
    @(negedge clk);
    bus.cache_addr = 32'h10;
    #2;
    check("idle_hit", {31'b0, bus.hit}, 32'h0);
    check("idle_dout", bus.cache_data_out, 32'hDEAD_BEEF);
    @(negedge clk);
    #2;
    check("idle_wen", {31'b0, bus.mem_write_en}, 32'h0);

    // Write-through store hitting a valid line.
    run_store("st10", 32'h10, 32'h1122_3344);
    run_load("ld10", 32'h10, -1, 32'h0, lat, dout);
    check("ld10_const", dout, 32'h1122_3344);

    // Conflict on index 4.
    run_load("c110", 32'h110, -1, 32'h0, lat, dout);
    check("c110_lat_const", 32'(lat), 32'd5);
    run_load("c10", 32'h10, -1, 32'h0, lat, dout);
    check("c10_lat_const", 32'(lat), 32'd5);

    // Store to a cold line.
    run_store("st20", 32'h20, 32'h5566_7788);
    run_load("ld20", 32'h20, -1, 32'h0, lat, dout);
`ifdef DCACHE_WRITE_ALLOCATE_EN
    check("ld20_lat_const", 32'(lat), 32'd0);
`else
    check("ld20_lat_const", 32'(lat), 32'd5);
`endif

    // Reset on the second write cycle abandons the store.
    run_load("r39_fill", 32'h30, -1, 32'h0, lat, dout);
    @(negedge clk);
    bus.cache_we      = 1'b1;
    bus.cache_addr    = 32'h30;
    bus.cache_data_in = 32'hCAFE_F00D;
    bus.cache_en      = 1'b1;
    @(negedge clk);
    #2;
    check("r39_wen_c1", {31'b0, bus.mem_write_en}, 32'h1);
    @(negedge clk);
    #2;
    check("r39_wen_c2", {31'b0, bus.mem_write_en}, 32'h1);
    rst_b = 1'b0;
    #1;
    check("r39_wen_rst", {31'b0, bus.mem_write_en}, 32'h0);
    check("r39_hit_rst", {31'b0, bus.hit}, 32'h0);
    check("r39_maddr_rst", bus.mem_addr, 32'h0);
    bus.cache_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #2;
      check("r39_hit_hold", {31'b0, bus.hit}, 32'h0);
    end
    @(negedge clk);
    rst_b = 1'b1;
    foreach (rv[i]) rv[i] = 1'b0;
    run_load("r39_reload", 32'h30, -1, 32'h0, lat, dout);
    check("r39_reload_lat_const", 32'(lat), 32'd5);

    // Address change during RD_WAIT: fill 0x10, then 0x40 as its own miss.
    run_load("chg", 32'h10, 2, 32'h40, lat, dout);
    check("chg_lat_const", 32'(lat), 32'd10);
    run_load("chg_after10", 32'h10, -1, 32'h0, lat, dout);
    check("chg_after10_const", dout, 32'h1122_3344);

    // Random mix over a small address pool to force hits, conflicts and mid-wait changes.
    for (int i = 0; i < 80; i++) begin
      ra  = rnd_addr();
      ra2 = rnd_addr();
      if ($urandom_range(0, 2) == 0)
        run_store("rnd_st", ra, $urandom);
      else
        run_load("rnd_ld", ra, ($urandom_range(0, 3) == 0) ? 2 : -1, ra2, lat, dout);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_dcache.md
MIPS_DCACHE -- requirements
Module: mips_dcache

Interface
REQ-001 Parameter LINES, default 64, number of direct-mapped one-word lines; must be a power of two, 2..1024.
REQ-002 Parameter MEM_LATENCY, default 4, backing-memory access time in cycles; range 1..15.
REQ-003 Port clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port rst_b  input  1  reset: rst_b, asynchronous, active-low.
REQ-005 Port cache_en  input  1  core request valid; held high until hit is seen.
REQ-006 Port cache_we  input  1  1 = store, 0 = load; qualified by cache_en.
REQ-007 Port cache_addr  input  32  byte address; bits [1:0] are ignored.
REQ-008 Port cache_data_in  input  4x8  store word; byte [0] is bits 31:24.
REQ-009 Port cache_data_out  output  4x8  load word; byte [0] is bits 31:24.
REQ-010 Port hit  output  1  request completes this cycle.
REQ-011 Port mem_addr  output  32  word-aligned backing-memory address.
REQ-012 Port mem_data_in  output  4x8  write data to backing memory.
REQ-013 Port mem_data_out  input  4x8  read data from backing memory.
REQ-014 Port mem_write_en  output  1  backing-memory write strobe.

Function
REQ-015 Address split: index = addr[2+IB-1:2], tag = addr[31:2+IB], where IB = log2(LINES); each line holds a valid bit, a tag and one 32-bit word.
REQ-016 The FSM has four states: IDLE, RD_WAIT, WR_WAIT and DONE.
REQ-017 IDLE, load hit (cache_en=1, cache_we=0, valid, tag match): hit=1 combinationally in the same cycle, cache_data_out = line word, state stays IDLE.
REQ-018 IDLE, load miss: latch the word address into mem_addr, load the counter with MEM_LATENCY, go to RD_WAIT; hit=0.
REQ-019 RD_WAIT: the counter decrements each cycle; when it reaches 1, capture mem_data_out into the line, set valid, write the tag and go to IDLE, where the following cycle hits.
REQ-020 Load miss latency from cache_en rising to hit = MEM_LATENCY+1 cycles.
REQ-021 IDLE, store (cache_en=1, cache_we=1): latch the address and data to mem_addr/mem_data_in, load the counter and go to WR_WAIT (write-through).
REQ-022 WR_WAIT: mem_write_en=1 for exactly MEM_LATENCY cycles; on the last cycle a matching valid line is updated with the store data; then go to DONE.
REQ-023 DONE: hit=1 for exactly one cycle, then go to IDLE; this prevents the still-high cache_en from re-triggering the store.
REQ-024 Store latency from cache_en rising to hit = MEM_LATENCY+1 cycles.
REQ-025 mem_write_en=0 in every state except WR_WAIT; mem_addr/mem_data_in hold their last latched value outside the wait states.
REQ-026 hit is 0 in RD_WAIT and WR_WAIT regardless of the inputs.
REQ-027 A change of cache_addr, cache_we or cache_data_in during RD_WAIT or WR_WAIT is ignored: the transaction completes on the latched values, and the new request is evaluated in IDLE.
REQ-028 cache_en=0 in IDLE: no state change and hit=0; cache_data_out still shows the indexed line word.
REQ-029 A counter value of MEM_LATENCY=1 gives a single wait cycle; the counter never underflows.

Reset
REQ-030 rst_b=0 asynchronously forces state=IDLE, counter=0, all valid bits=0, hit=0, mem_write_en=0, mem_addr=0, mem_data_in=0 and cache_data_out=0.
REQ-031 Reset asserted mid-transaction abandons it: no line is written and mem_write_en drops immediately.
REQ-032 Line data and tag arrays need not be reset; valid=0 masks them.

Configuration
REQ-033 Macro DCACHE_WRITE_ALLOCATE_EN: when defined, a store miss at the end of WR_WAIT installs the line (valid=1, tag, data); when undefined, a store miss leaves the cache unchanged (no-allocate).
REQ-034 Store latency and memory traffic are identical with and without DCACHE_WRITE_ALLOCATE_EN.

Verification
REQ-035 After reset, load 0x0000_0010 with mem word 0xDEADBEEF -> hit on cycle 5 (MEM_LATENCY=4), data_out bytes DE,AD,BE,EF; a repeat load hits in the same cycle.
REQ-036 Store 0x1122_3344 to 0x10 after the previous fill -> mem_write_en high for 4 cycles at mem_addr 0x10, hit on cycle 5, then a load of 0x10 hits same-cycle with 0x11223344.
REQ-037 Conflict test: load 0x10, then load 0x110 (same index, tag 1) -> the second load misses with 5-cycle latency; reloading 0x10 misses again.
REQ-038 Store to cold 0x20, then load 0x20 -> the load misses without DCACHE_WRITE_ALLOCATE_EN and hits same-cycle with it.
REQ-039 Assert rst_b=0 on cycle 2 of WR_WAIT -> mem_write_en=0 immediately, hit never pulses, and the next load of that address misses.
REQ-040 Change cache_addr from 0x10 to 0x40 during RD_WAIT -> the fill targets 0x10, then 0x40 is handled as a fresh miss.
